// File: rtl/tvm_vpi_ram_dma_if.sv
// Command and RAM-side signal bundle for tvm_vpi_ram_dma.
// master is the copy sequencer; slave is the host plus RAM environment.
interface tvm_vpi_ram_dma_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_src_addr;
  logic [31:0]      cmd_dst_addr;
  logic [31:0]      cmd_size;
  logic             busy;
  logic             done;
  logic             ram_read_req;
  logic [31:0]      ram_read_addr;
  logic [31:0]      ram_read_size;
  logic             ram_write_req;
  logic [31:0]      ram_write_addr;
  logic [31:0]      ram_write_size;
  logic             ram_read_dequeue;
  logic [WIDTH-1:0] ram_read_data;
  logic             ram_read_valid;
  logic             ram_write_enable;
  logic [WIDTH-1:0] ram_write_data;
  logic             ram_write_full;

  modport master (
    input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_size,
    input  ram_read_data, ram_read_valid, ram_write_full,
    output cmd_ready, busy, done,
    output ram_read_req, ram_read_addr, ram_read_size,
    output ram_write_req, ram_write_addr, ram_write_size,
    output ram_read_dequeue, ram_write_enable, ram_write_data
  );

  modport slave (
    output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_size,
    output ram_read_data, ram_read_valid, ram_write_full,
    input  cmd_ready, busy, done,
    input  ram_read_req, ram_read_addr, ram_read_size,
    input  ram_write_req, ram_write_addr, ram_write_size,
    input  ram_read_dequeue, ram_write_enable, ram_write_data
  );
endinterface

// File: rtl/tvm_vpi_ram_dma.sv
// Copy sequencer: splits a word copy into bursts of at most MAX_BURST words and
// streams each word from the RAM read port to its write port.
module tvm_vpi_ram_dma #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  tvm_vpi_ram_dma_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StMove, StDone} state_e;

  localparam logic [31:0] MaxBurst = 32'(MAX_BURST);

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] size_q, size_d;
  logic [31:0] burst_now;
  logic        beat;
  logic        issuing;

  assign burst_now = (rem_q < MaxBurst) ? rem_q : MaxBurst;
  assign issuing   = (state_q == StIssue);
  // Beat handshake stays purely combinational on the stream flags.
  assign beat      = (state_q == StMove) && bus.ram_read_valid && !bus.ram_write_full;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    size_d     = size_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          src_d   = bus.cmd_src_addr;
          dst_d   = bus.cmd_dst_addr;
          rem_d   = bus.cmd_size;
          state_d = (bus.cmd_size == 32'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        burst_d    = burst_now;
        beat_cnt_d = 32'd0;
        rd_addr_d  = src_q;
        wr_addr_d  = dst_q;
        size_d     = burst_now;
        state_d    = StMove;
      end
      StMove: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          if (beat_cnt_d == burst_q) begin
            rem_d   = rem_q - burst_q;
            src_d   = src_q + burst_q;
            dst_d   = dst_q + burst_q;
            state_d = (rem_q == burst_q) ? StDone : StIssue;
          end
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      size_q     <= size_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

  // Request fields are live during ISSUE and hold the last issued burst afterwards.
  assign bus.ram_read_req   = issuing;
  assign bus.ram_write_req  = issuing;
  assign bus.ram_read_addr  = issuing ? src_q : rd_addr_q;
  assign bus.ram_write_addr = issuing ? dst_q : wr_addr_q;
  assign bus.ram_read_size  = issuing ? burst_now : size_q;
  assign bus.ram_write_size = issuing ? burst_now : size_q;

  assign bus.ram_read_dequeue = beat;
  assign bus.ram_write_enable = beat;
  assign bus.ram_write_data   = bus.ram_read_data;

endmodule
